wb_mem_arbiter: RTL and testbench

- Two-master Wishbone B3 classic arbiter that shares the single Wishbone memory slave (the Tx/Rx data RAM model) between the Ethernet MAC DMA master (m0) and the host/bench loader master (m1).
- Performs round-robin grant per bus cycle and forwards the slave's ack/err/rty to the owner only.
- Arbitration fairness is re-applied after every retry.
- A response watchdog terminates hung transfers with err, so a non-responding slave cannot lock the bus.

---
 rtl/wb_arb_pkg.sv | 38 +++
 rtl/wb_arb_watchdog.sv | 36 +++
 rtl/wb_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone memory arbiter.
package wb_arb_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 32;
  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;
  localparam int unsigned WD_WIDTH      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    TOUT = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                     cyc;
    logic                     stb;
    logic                     we;
    logic [WB_ADDR_WIDTH-1:0] adr;
    logic [WB_SEL_WIDTH-1:0]  sel;
    logic [WB_DATA_WIDTH-1:0] dat;
  } wb_req_t;

  typedef struct packed {
    logic                     ack;
    logic                     err;
    logic                     rty;
    logic [WB_DATA_WIDTH-1:0] dat;
  } wb_rsp_t;

  // Outside IDLE the last granted master is always the current owner.
  function automatic logic [1:0] owner_onehot(arb_state_t st, logic owner);
    if (st == IDLE) return 2'b00;
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Response watchdog: counts unanswered strobe cycles and fires on the last allowed one.
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT   = 256,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic fire_o
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign fire_o = enable_i && !clear_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || fire_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone B3 classic arbiter in front of the shared data RAM slave.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 256,
  parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  m0_wb_cyc_i,
  input  logic                  m0_wb_stb_i,
  input  logic                  m0_wb_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_wb_adr_i,
  input  logic [SEL_WIDTH-1:0]  m0_wb_sel_i,
  input  logic [DATA_WIDTH-1:0] m0_wb_dat_i,
  output logic                  m0_wb_ack_o,
  output logic                  m0_wb_err_o,
  output logic                  m0_wb_rty_o,
  output logic [DATA_WIDTH-1:0] m0_wb_dat_o,
  input  logic                  m1_wb_cyc_i,
  input  logic                  m1_wb_stb_i,
  input  logic                  m1_wb_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_wb_adr_i,
  input  logic [SEL_WIDTH-1:0]  m1_wb_sel_i,
  input  logic [DATA_WIDTH-1:0] m1_wb_dat_i,
  output logic                  m1_wb_ack_o,
  output logic                  m1_wb_err_o,
  output logic                  m1_wb_rty_o,
  output logic [DATA_WIDTH-1:0] m1_wb_dat_o,
  output logic                  s_wb_cyc_o,
  output logic                  s_wb_stb_o,
  output logic                  s_wb_we_o,
  output logic [ADDR_WIDTH-1:0] s_wb_adr_o,
  output logic [SEL_WIDTH-1:0]  s_wb_sel_o,
  output logic [DATA_WIDTH-1:0] s_wb_dat_o,
  input  logic                  s_wb_ack_i,
  input  logic                  s_wb_err_i,
  input  logic                  s_wb_rty_i,
  input  logic [DATA_WIDTH-1:0] s_wb_dat_i,
  output logic [1:0]            gnt_o,
  output logic                  timeout_o
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       own, tout, own_cyc, oth_cyc;
  logic       wd_en, wd_fire;

  assign own     = (state_q == OWN0) || (state_q == OWN1);
  assign tout    = (state_q == TOUT);
  assign own_cyc = last_q ? m1_wb_cyc_i : m0_wb_cyc_i;
  assign oth_cyc = last_q ? m0_wb_cyc_i : m1_wb_cyc_i;

  always_comb begin
    s_wb_cyc_o = 1'b0;
    s_wb_stb_o = 1'b0;
    s_wb_we_o  = 1'b0;
    s_wb_adr_o = '0;
    s_wb_sel_o = '0;
    s_wb_dat_o = '0;
    if (own && last_q) begin
      s_wb_cyc_o = m1_wb_cyc_i;
      s_wb_stb_o = m1_wb_cyc_i & m1_wb_stb_i;
      s_wb_we_o  = m1_wb_we_i;
      s_wb_adr_o = m1_wb_adr_i;
      s_wb_sel_o = m1_wb_sel_i;
      s_wb_dat_o = m1_wb_dat_i;
    end else if (own) begin
      s_wb_cyc_o = m0_wb_cyc_i;
      s_wb_stb_o = m0_wb_cyc_i & m0_wb_stb_i;
      s_wb_we_o  = m0_wb_we_i;
      s_wb_adr_o = m0_wb_adr_i;
      s_wb_sel_o = m0_wb_sel_i;
      s_wb_dat_o = m0_wb_dat_i;
    end
  end

  // Slave terminations reach only the owner; anything outside OWNx is dropped.
  assign m0_wb_ack_o = own & ~last_q & s_wb_ack_i;
  assign m0_wb_err_o = (own & ~last_q & s_wb_err_i) | (tout & ~last_q);
  assign m0_wb_rty_o = own & ~last_q & s_wb_rty_i;
  assign m1_wb_ack_o = own & last_q & s_wb_ack_i;
  assign m1_wb_err_o = (own & last_q & s_wb_err_i) | (tout & last_q);
  assign m1_wb_rty_o = own & last_q & s_wb_rty_i;
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

  assign gnt_o     = owner_onehot(state_q, last_q);
  assign timeout_o = tout;

  assign wd_en = own & s_wb_stb_o & ~(s_wb_ack_i | s_wb_err_i | s_wb_rty_i);

  wb_arb_watchdog #(
    .TIMEOUT  (TIMEOUT),
    .CNT_WIDTH(WD_WIDTH)
  ) u_watchdog (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n_i),
    .clear_i (~wd_en),
    .enable_i(wd_en),
    .fire_o  (wd_fire)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          last_d  = ~last_q;
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_wb_cyc_i) begin
          last_d  = 1'b0;
          state_d = OWN0;
        end else if (m1_wb_cyc_i) begin
          last_d  = 1'b1;
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        // err holds the grant; rty yields only when the other master is waiting
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (s_wb_err_i) begin
          state_d = state_q;
        end else if (s_wb_rty_i && oth_cyc) begin
          state_d = IDLE;
        end else if (wd_fire) begin
          state_d = TOUT;
        end
      end
      TOUT: begin
        if (own_cyc) begin
          state_d = last_q ? OWN1 : OWN0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Randomized self-checking bench for wb_mem_arbiter against an ownership-level reference model.
module tb_wb_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 4;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [AW-1:0] m_adr [2];
  logic [SW-1:0] m_sel [2];
  logic [DW-1:0] m_dat [2];

  logic m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [DW-1:0] m0_rdat, m1_rdat;
  logic s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [SW-1:0] s_sel;
  logic [DW-1:0] s_wdat, s_rdat;
  logic s_ack, s_err, s_rty;
  logic [1:0] gnt;
  logic tmo;

  // Slave RAM: answers combinationally according to slv_mode (0 none, 1 ack, 2 err, 3 rty).
  int unsigned slv_mode;
  logic        spur_ack;
  logic [DW-1:0] mem [256];

  assign s_ack  = spur_ack | (slv_mode == 1 && s_cyc && s_stb);
  assign s_err  = (slv_mode == 2 && s_cyc && s_stb);
  assign s_rty  = (slv_mode == 3 && s_cyc && s_stb);
  assign s_rdat = mem[s_adr[9:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (s_cyc && s_stb && s_we && s_ack) begin
      for (int b = 0; b < SW; b++)
        if (s_sel[b]) mem[s_adr[9:2]][b*8 +: 8] <= s_wdat[b*8 +: 8];
    end
  end

  wb_mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TMO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .m0_wb_cyc_i(m_cyc[0]),
    .m0_wb_stb_i(m_stb[0]),
    .m0_wb_we_i (m_we[0]),
    .m0_wb_adr_i(m_adr[0]),
    .m0_wb_sel_i(m_sel[0]),
    .m0_wb_dat_i(m_dat[0]),
    .m0_wb_ack_o(m0_ack),
    .m0_wb_err_o(m0_err),
    .m0_wb_rty_o(m0_rty),
    .m0_wb_dat_o(m0_rdat),
    .m1_wb_cyc_i(m_cyc[1]),
    .m1_wb_stb_i(m_stb[1]),
    .m1_wb_we_i (m_we[1]),
    .m1_wb_adr_i(m_adr[1]),
    .m1_wb_sel_i(m_sel[1]),
    .m1_wb_dat_i(m_dat[1]),
    .m1_wb_ack_o(m1_ack),
    .m1_wb_err_o(m1_err),
    .m1_wb_rty_o(m1_rty),
    .m1_wb_dat_o(m1_rdat),
    .s_wb_cyc_o (s_cyc),
    .s_wb_stb_o (s_stb),
    .s_wb_we_o  (s_we),
    .s_wb_adr_o (s_adr),
    .s_wb_sel_o (s_sel),
    .s_wb_dat_o (s_wdat),
    .s_wb_ack_i (s_ack),
    .s_wb_err_i (s_err),
    .s_wb_rty_i (s_rty),
    .s_wb_dat_i (s_rdat),
    .gnt_o      (gnt),
    .timeout_o  (tmo)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: who owns the bus, whether this is the timeout cycle, unanswered strobe count.
  int own    = -1;
  int last   = 1;
  bit tout   = 1'b0;
  int wait_n = 0;

  bit          term_seen [2];
  int          left      [2];
  bit          burst     [2];
  bit          wr_only   = 1'b0;
  logic [DW-1:0] bwords  [16];

  task automatic step();
    int   oi;
    logic ec, es;
    logic [1:0] eg;
    logic [2:0] et [2];
    #1;
    oi = (own == 1) ? 1 : 0;
    eg = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
    ec = !tout && own >= 0 && m_cyc[oi];
    es = ec && m_stb[oi];
    for (int i = 0; i < 2; i++) begin
      et[i][2] = !tout && own == i && s_ack;
      et[i][1] = own == i && (tout || s_err);
      et[i][0] = !tout && own == i && s_rty;
    end
    check("gnt", gnt, eg);
    check("s_cyc_stb", {s_cyc, s_stb}, {ec, es});
    if (ec) check("s_req", {s_we, s_sel, s_adr, s_wdat}, {m_we[oi], m_sel[oi], m_adr[oi], m_dat[oi]});
    check("m0_term", {m0_ack, m0_err, m0_rty}, et[0]);
    check("m1_term", {m1_ack, m1_err, m1_rty}, et[1]);
    check("timeout", tmo, tout);
    check("rdat", {m0_rdat, m1_rdat}, {s_rdat, s_rdat});
    term_seen[0] = m0_ack | m0_err | m0_rty;
    term_seen[1] = m1_ack | m1_err | m1_rty;

    if (!rst_n) begin
      own = -1; last = 1; tout = 1'b0; wait_n = 0;
    end else if (tout) begin
      tout = 1'b0;
      if (!m_cyc[oi]) own = -1;
    end else if (own < 0) begin
      if (m_cyc[0] && m_cyc[1]) own = 1 - last;
      else if (m_cyc[0])        own = 0;
      else if (m_cyc[1])        own = 1;
      if (own >= 0) last = own;
      wait_n = 0;
    end else if (!m_cyc[oi]) begin
      own = -1; wait_n = 0;
    end else if (s_err) begin
      wait_n = 0;
    end else if (s_rty && m_cyc[1-oi]) begin
      own = -1; wait_n = 0;
    end else if (s_ack || s_rty || !m_stb[oi]) begin
      wait_n = 0;
    end else begin
      wait_n++;
      if (wait_n == TMO) begin
        tout = 1'b1; wait_n = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Behavioural masters: finish one transfer per termination, bursts keep cyc high.
  task automatic drive_masters();
    for (int i = 0; i < 2; i++) begin
      if (m_cyc[i] && term_seen[i]) begin
        left[i]--;
        if (left[i] > 0 && burst[i]) begin
          m_adr[i] = m_adr[i] + 32'd4;
          m_dat[i] = $urandom;
          if (i == 0) bwords[m_adr[0][5:2]] = m_dat[0];
        end else begin
          m_cyc[i] = 1'b0;
          m_stb[i] = 1'b0;
        end
      end else if (!m_cyc[i] && left[i] > 0) begin
        m_cyc[i] = 1'b1;
        m_stb[i] = 1'b1;
        m_dat[i] = $urandom;
        if (burst[i]) begin
          m_we[i]  = 1'b1;
          m_sel[i] = 4'hF;
          m_adr[i] = '0;
          if (i == 0) bwords[0] = m_dat[0];
        end else begin
          m_we[i]  = wr_only ? 1'b1 : 1'($urandom_range(0, 1));
          m_sel[i] = 4'($urandom_range(1, 15));
          m_adr[i] = 32'($urandom_range(64, 255)) << 2;
        end
      end
    end
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles);
    bit done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      step();
      drive_masters();
      done = (left[0] == 0 && left[1] == 0 && !m_cyc[0] && !m_cyc[1]);
    end
    check(tag, done, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exhausted");
  end

  initial begin
    logic [1:0] gq[$];
    logic [1:0] prev;
    int         n;
    bit         seen;

    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      m_adr[i] = '0; m_sel[i] = '0; m_dat[i] = '0;
      left[i] = 0; burst[i] = 1'b0; term_seen[i] = 1'b0;
    end
    slv_mode = 0;
    spur_ack = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with m0 requesting, then first grant one cycle after release.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
    m_adr[0] = 32'h0000_0140; m_sel[0] = 4'hF; left[0] = 1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_gnt", gnt, 2'b01);
    check("rst_adr", s_adr, 32'h0000_0140);
    slv_mode = 1;
    run_until_idle("rst_done", 20);

    // Simultaneous requests: m0 twice, m1 once, grants must alternate.
    wr_only = 1'b1;
    left[0] = 2; left[1] = 1;
    drive_masters();
    prev = 2'b00;
    for (int c = 0; c < 40 && (left[0] > 0 || left[1] > 0 || m_cyc[0] || m_cyc[1]); c++) begin
      step();
      if (gnt != 2'b00 && gnt != prev) gq.push_back(gnt);
      prev = gnt;
      drive_masters();
    end
    wr_only = 1'b0;
    check("tie_len", 32'(gq.size()), 32'd3);
    if (gq.size() >= 3) begin
      check("tie_g0", gq[0], 2'b01);
      check("tie_g1", gq[1], 2'b10);
      check("tie_g2", gq[2], 2'b01);
    end
    step();

    // Retry with the other master waiting hands the bus over after a one-cycle gap.
    slv_mode = 0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h10;
    step();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h200;
    slv_mode = 3;
    #1;
    check("rty_m0", m0_rty, 1'b1);
    check("rty_m1", m1_rty, 1'b0);
    step();
    slv_mode = 0;
    #1;
    check("rty_gap", s_cyc, 1'b0);
    step();
    check("rty_gnt", gnt, 2'b10);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    step();

    // Non-responding slave: TMO strobe cycles, then a single err/timeout cycle.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h20;
    n = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (s_stb) n++;
      if (tmo) begin
        seen = 1'b1;
        check("wd_err", m0_err, 1'b1);
        check("wd_stb", s_stb, 1'b0);
      end
      step();
    end
    check("wd_seen", seen, 1'b1);
    check("wd_cycles", 32'(n), 32'(TMO));
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    step();

    // Spurious ack while idle must not reach either master.
    spur_ack = 1'b1;
    #1;
    check("spur_ack", {m0_ack, m1_ack}, 2'b00);
    step();
    spur_ack = 1'b0;
    check("spur_idle", gnt, 2'b00);
    step();

    // 16-word burst from m0 is not preempted by m1's request.
    slv_mode = 1;
    burst[0] = 1'b1; left[0] = 16;
    drive_masters();
    step();
    left[1] = 1;
    n = 0;
    for (int c = 0; c < 60 && (left[0] > 0 || left[1] > 0 || m_cyc[0] || m_cyc[1]); c++) begin
      step();
      if (gnt == 2'b10 && left[0] > 0) n++;
      drive_masters();
    end
    check("burst_hold", 32'(n), 32'd0);
    check("burst_done", {left[0] == 0, left[1] == 0}, 2'b11);
    for (int k = 0; k < 16; k++) check($sformatf("burst_mem%0d", k), mem[k], bwords[k]);
    burst[0] = 1'b0;
    step();

    // Random traffic, slave behaviour, spurious acks and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 9))
          0, 1:          slv_mode = 0;
          2, 3, 4, 5, 6: slv_mode = 1;
          7:             slv_mode = 2;
          default:       slv_mode = 3;
        endcase
      end
      spur_ack = ($urandom_range(0, 49) == 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < 2; i++) begin
        if (left[i] == 0 && !m_cyc[i] && $urandom_range(0, 7) == 0) begin
          left[i]  = $urandom_range(1, 4);
          burst[i] = 1'($urandom_range(0, 1));
        end
      end
      step();
      drive_masters();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
